// File: rtl/trap_exception_ctrl.sv
// trap_exception_ctrl: CP0 Status/Cause/EPC holder and exception-entry
// sequencer. Accepts SYSCALL/BREAK trap codes from decode, flushes the
// pipeline for FLUSH_CYCLES cycles, then issues a one-cycle fetch redirect
// to the exception vector (or to EPC for ERET). Also serves MFC0/MTC0.
module trap_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [5:0]  trap_type,
  input  logic [31:0] trap_pc,
  input  logic        in_delay_slot,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [2:0]  FLUSH_LOAD   = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt;
  logic [31:0] status_q;
  logic        cause_bd_q;
  logic [4:0]  cause_code_q;
  logic [31:0] epc_q;
  logic [31:0] target_q;
  logic [31:0] redirect_pc_q;

  logic        idle;
  logic        trap_acc;
  logic        eret_acc;
  logic        mtc0_acc;
  logic        redirect_load;
  logic [31:0] epc_new;
  logic [31:0] cause_word;

  // Accept qualification: only IDLE listens, trap beats eret beats MTC0.
  always_comb begin
    idle          = (state == ST_IDLE);
    trap_acc      = idle && trap_valid && !trap_type[5] && (trap_type[4:0] != 5'd0);
    eret_acc      = idle && eret && status_q[1] && !trap_acc;
    mtc0_acc      = idle && cp0_we && !trap_acc && !eret_acc;
    redirect_load = (state == ST_FLUSH) && (state_nxt == ST_REDIRECT);
    epc_new       = in_delay_slot ? (trap_pc - 32'd4) : trap_pc;
    cause_word    = {cause_bd_q, 24'd0, cause_code_q, 2'b00};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> FLUSH on accept, FLUSH counts down, REDIRECT lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (trap_acc || eret_acc) state_nxt = ST_FLUSH;
      ST_FLUSH:    if (flush_cnt <= 3'd1)    state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from state; redirect_pc comes from its own holding register.
  always_comb begin
    flush          = (state == ST_FLUSH);
    busy           = (state != ST_IDLE);
    redirect_valid = (state == ST_REDIRECT);
    redirect_pc    = redirect_pc_q;
    exl            = status_q[1];
  end

  // Flush-length counter, loaded on accept and decremented while flushing.
  always_ff @(posedge clk) begin
    if (rst)                        flush_cnt <= 3'd0;
    else if (trap_acc || eret_acc)  flush_cnt <= FLUSH_LOAD;
    else if (state == ST_FLUSH)     flush_cnt <= flush_cnt - 3'd1;
  end

  // Status: trap sets EXL, ERET clears it, MTC0 writes the masked bits.
  always_ff @(posedge clk) begin
    if (rst)           status_q <= 32'd0;
    else if (trap_acc) status_q[1] <= 1'b1;
    else if (eret_acc) status_q[1] <= 1'b0;
    else if (mtc0_acc && cp0_waddr == REG_STATUS)
      status_q <= (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
  end

  // Cause: ExcCode always updated on trap; BD only on a first-level trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_bd_q   <= 1'b0;
      cause_code_q <= 5'd0;
    end else if (trap_acc) begin
      cause_code_q <= trap_type[4:0];
      if (!status_q[1]) cause_bd_q <= in_delay_slot;
    end
  end

  // EPC: captured on first-level trap (rewound for delay slot), else MTC0.
  always_ff @(posedge clk) begin
    if (rst)                                     epc_q <= 32'd0;
    else if (trap_acc && !status_q[1])           epc_q <= epc_new;
    else if (mtc0_acc && cp0_waddr == REG_EPC)   epc_q <= cp0_wdata;
  end

  // Redirect target latched at accept; copied to the output on entering REDIRECT
  // so redirect_pc only changes when a redirect is actually emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      if (trap_acc)      target_q <= EXC_VECTOR;
      else if (eret_acc) target_q <= epc_q;
      if (redirect_load) redirect_pc_q <= target_q;
    end
  end

  // MFC0 read port, no bypass of same-cycle writes.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      REG_STATUS: cp0_rdata = status_q;
      REG_CAUSE:  cp0_rdata = cause_word;
      REG_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_trap_exception_ctrl.sv
// Bench for trap_exception_ctrl: timeline-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_trap_exception_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;
  localparam int          F   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [5:0]  trap_type;
  logic [31:0] trap_pc;
  logic        in_delay_slot;
  logic        eret;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush, busy, redirect_valid, exl;
  logic [31:0] redirect_pc;

  trap_exception_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_type(trap_type),
    .trap_pc(trap_pc), .in_delay_slot(in_delay_slot), .eret(eret),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exl(exl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the edge index of the last
  // accepted trap/ERET. Outputs follow from arithmetic on that edge index.
  int          cyc = 0;
  int          acc = -1000;
  logic [31:0] m_status = 32'd0;
  logic        m_bd = 1'b0;
  logic [4:0]  m_code = 5'd0;
  logic [31:0] m_epc = 32'd0;
  logic [31:0] m_target = 32'd0;
  logic [31:0] m_rpc = 32'd0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_status;
      5'd13:   return {m_bd, 24'd0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_status = 0; m_bd = 0; m_code = 0; m_epc = 0; m_target = 0; m_rpc = 0;
      acc = -1000;
    end else begin
      if (!(acc <= cyc - 1 && cyc - 1 <= acc + F)) begin
        if (trap_valid && trap_type != 0 && trap_type < 32) begin
          if (!m_status[1]) begin
            m_epc = in_delay_slot ? trap_pc - 32'd4 : trap_pc;
            m_bd  = in_delay_slot;
          end
          m_code = trap_type[4:0];
          m_status[1] = 1'b1;
          m_target = VEC;
          acc = cyc;
        end else if (eret && m_status[1]) begin
          m_status[1] = 1'b0;
          m_target = m_epc;
          acc = cyc;
        end else if (cp0_we) begin
          if (cp0_waddr == 5'd12) m_status = cp0_wdata & 32'h0000_FF03;
          if (cp0_waddr == 5'd14) m_epc = cp0_wdata;
        end
      end
      if (cyc == acc + F) m_rpc = m_target;
    end
  end

  // Per-cycle comparison, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("flush",          {31'd0, flush},          {31'd0, (acc <= cyc && cyc < acc + F)});
      chk("busy",           {31'd0, busy},           {31'd0, (acc <= cyc && cyc <= acc + F)});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, (cyc == acc + F)});
      chk("redirect_pc",    redirect_pc,             m_rpc);
      chk("exl",            {31'd0, exl},            {31'd0, m_status[1]});
      chk("cp0_rdata",      cp0_rdata,               m_read(cp0_raddr));
    end
  end

  task automatic clear_inputs();
    trap_valid = 0; trap_type = 0; trap_pc = 0; in_delay_slot = 0;
    eret = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
  endtask

  // Presents a trap (optionally with eret) for one edge; returns in the cycle after that edge.
  task automatic drive_trap(input logic [5:0] t, input logic [31:0] pc, input logic ds, input logic er);
    @(negedge clk);
    trap_valid = 1; trap_type = t; trap_pc = pc; in_delay_slot = ds; eret = er;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic drive_eret();
    @(negedge clk); eret = 1;
    @(negedge clk); eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    @(negedge clk); cp0_we = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    cp0_raddr = a; #1;
    chk(name, cp0_rdata, exp);
  endtask

  initial begin
    clear_inputs();
    cp0_raddr = 5'd12;
    rst = 1;
    wait_cyc(2);
    chk_en = 1;
    rst = 0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    lit_rd("reset status", 5'd12, 32'd0);
    lit_rd("reset cause",  5'd13, 32'd0);
    lit_rd("reset epc",    5'd14, 32'd0);

    // Syscall with literal latency pinning.
    drive_trap(6'd8, 32'h0040_0020, 1'b0, 1'b0);
    chk("sys flush1", {31'd0, flush}, 32'd1);
    wait_cyc(1);
    chk("sys flush2", {31'd0, flush}, 32'd1);
    wait_cyc(1);
    chk("sys redir",    {31'd0, redirect_valid}, 32'd1);
    chk("sys redir_pc", redirect_pc, 32'h8000_0180);
    chk("sys redir nf", {31'd0, flush}, 32'd0);
    wait_cyc(1);
    chk("sys idle", {31'd0, busy}, 32'd0);
    lit_rd("sys epc",    5'd14, 32'h0040_0020);
    lit_rd("sys cause",  5'd13, 32'h0000_0020);
    lit_rd("sys status", 5'd12, 32'h0000_0002);

    // MTC0 EPC then ERET.
    mtc0(5'd14, 32'h0040_0024);
    drive_eret();
    wait_cyc(2);
    chk("eret redir_pc", redirect_pc, 32'h0040_0024);
    chk("eret exl", {31'd0, exl}, 32'd0);
    wait_cyc(1);
    drive_eret();
    chk("eret2 noflush", {31'd0, flush}, 32'd0);
    wait_cyc(3);

    // Break in delay slot.
    drive_trap(6'd9, 32'h0040_0104, 1'b1, 1'b0);
    wait_cyc(4);
    lit_rd("bp epc",   5'd14, 32'h0040_0100);
    lit_rd("bp cause", 5'd13, 32'h8000_0024);
    chk("bp redir_pc", redirect_pc, 32'h8000_0180);

    // Trap together with eret (EXL=1): trap wins, nested so BD/EPC kept.
    drive_trap(6'd8, 32'h0000_0500, 1'b0, 1'b1);
    wait_cyc(4);
    lit_rd("coll cause", 5'd13, 32'h8000_0020);
    chk("coll exl", {31'd0, exl}, 32'd1);

    // Nested trap with EXL=1.
    drive_trap(6'd9, 32'h0000_1000, 1'b0, 1'b0);
    // Trap during FLUSH is ignored.
    trap_valid = 1; trap_type = 6'd3; trap_pc = 32'h0000_2000;
    wait_cyc(1);
    clear_inputs();
    wait_cyc(3);
    lit_rd("nest epc",   5'd14, 32'h0040_0100);
    lit_rd("nest cause", 5'd13, 32'h8000_0024);

    // trap_type 0 and >=32 are ignored.
    drive_trap(6'd0, 32'h0000_3000, 1'b0, 1'b0);
    chk("type0 idle", {31'd0, busy}, 32'd0);
    drive_trap(6'd40, 32'h0000_3000, 1'b0, 1'b0);
    chk("type40 idle", {31'd0, busy}, 32'd0);

    // MTC0 masking and dropped writes.
    mtc0(5'd12, 32'hFFFF_FFFF);
    lit_rd("status mask", 5'd12, 32'h0000_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    lit_rd("cause ro", 5'd13, 32'h8000_0024);
    mtc0(5'd5, 32'h1234_5678);
    lit_rd("reg5 zero", 5'd5, 32'd0);
    mtc0(5'd12, 32'h0000_0000);
    // MTC0 with a trap in the same cycle is dropped.
    @(negedge clk);
    trap_valid = 1; trap_type = 6'd8; trap_pc = 32'h0000_4000;
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    clear_inputs();
    wait_cyc(3);
    lit_rd("mtc0 drop epc", 5'd14, 32'h0000_4000);
    mtc0(5'd12, 32'h0000_0000);

    // Reset in the first FLUSH cycle.
    drive_trap(6'd8, 32'h0000_5000, 1'b0, 1'b0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst flush", {31'd0, flush}, 32'd0);
    chk("rst busy",  {31'd0, busy}, 32'd0);
    chk("rst redir", {31'd0, redirect_valid}, 32'd0);
    chk("rst redir_pc", redirect_pc, 32'd0);
    lit_rd("rst status", 5'd12, 32'd0);
    lit_rd("rst cause",  5'd13, 32'd0);
    lit_rd("rst epc",    5'd14, 32'd0);
    wait_cyc(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
